// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param: requests, write data, thresholds and status.
// master drives requests and thresholds; slave is the FIFO side.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] Fifo_Data_in;
    logic [ADDR_WIDTH:0]   Umbral_Almost_Empty;
    logic [ADDR_WIDTH:0]   Umbral_Almost_Full;
    logic                  Error_Clear;
    logic [DATA_WIDTH-1:0] Fifo_Data_out;
    logic                  Fifo_Valid;
    logic [ADDR_WIDTH:0]   Fifo_Count;
    logic                  Fifo_Empty;
    logic                  Fifo_Full;
    logic                  Almost_Empty;
    logic                  Almost_Full;
    logic                  Pausa;
    logic                  Error_Overflow;
    logic                  Error_Underflow;
    logic                  Error_Fifo;

    modport master (
        output push, pop, Fifo_Data_in, Umbral_Almost_Empty, Umbral_Almost_Full, Error_Clear,
        input  Fifo_Data_out, Fifo_Valid, Fifo_Count, Fifo_Empty, Fifo_Full,
               Almost_Empty, Almost_Full, Pausa, Error_Overflow, Error_Underflow, Error_Fifo
    );

    modport slave (
        input  push, pop, Fifo_Data_in, Umbral_Almost_Empty, Umbral_Almost_Full, Error_Clear,
        output Fifo_Data_out, Fifo_Valid, Fifo_Count, Fifo_Empty, Fifo_Full,
               Almost_Empty, Almost_Full, Pausa, Error_Overflow, Error_Underflow, Error_Fifo
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, registered read port,
// hysteretic back-pressure (Pausa) and sticky overflow/underflow flags.
module fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input logic         clk,
    input logic         reset,
    fifo_param_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} pausa_state_t;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_r;
    logic                  ovf_r;
    logic                  unf_r;
    logic                  ovf_next_s;
    logic                  unf_next_s;
    pausa_state_t          state_r;
    pausa_state_t          state_next_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    assign empty_s   = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign pop_ok_s  = bus.pop & ~empty_s;
    // A full FIFO can still take a push when a pop frees the slot in the same cycle.
    assign push_ok_s = bus.push & (~full_s | pop_ok_s);

    // Next occupancy from the accepted operations.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Pausa next state; release wins when both thresholds are met.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (count_next_s <= bus.Umbral_Almost_Empty) begin
                    state_next_s = RUN;
                end else if (count_next_s >= bus.Umbral_Almost_Full) begin
                    state_next_s = PAUSE;
                end else begin
                    state_next_s = RUN;
                end
            end
            PAUSE: begin
                if (count_next_s <= bus.Umbral_Almost_Empty) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PAUSE;
                end
            end
            default: state_next_s = RUN;
        endcase
    end

    // Sticky error next values; a fresh error beats Error_Clear.
    always_comb begin
        ovf_next_s = ovf_r;
        unf_next_s = unf_r;
        if (bus.push & ~push_ok_s) begin
            ovf_next_s = 1'b1;
        end else if (bus.Error_Clear) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
        if (bus.pop & ~pop_ok_s) begin
            unf_next_s = 1'b1;
        end else if (bus.Error_Clear) begin
            unf_next_s = 1'b0;
        end else begin
            unf_next_s = unf_r;
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_ok_s & ~reset) begin
            mem_r[wr_ptr_r] <= bus.Fifo_Data_in;
        end
    end

    // Pointers, count, read port, Pausa state and error bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
            count_r    <= {CW{1'b0}};
            data_out_r <= {DATA_WIDTH{1'b0}};
            valid_r    <= 1'b0;
            state_r    <= RUN;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r   <= rd_ptr_r + ADDR_WIDTH'(1'b1);
                data_out_r <= mem_r[rd_ptr_r];
                valid_r    <= 1'b1;
            end else begin
                valid_r    <= 1'b0;
            end
            count_r <= count_next_s;
            state_r <= state_next_s;
            ovf_r   <= ovf_next_s;
            unf_r   <= unf_next_s;
        end
    end

    assign bus.Fifo_Data_out   = data_out_r;
    assign bus.Fifo_Valid      = valid_r;
    assign bus.Fifo_Count      = count_r;
    assign bus.Fifo_Empty      = empty_s;
    assign bus.Fifo_Full       = full_s;
    assign bus.Almost_Empty    = (count_r <= bus.Umbral_Almost_Empty);
    assign bus.Almost_Full     = (count_r >= bus.Umbral_Almost_Full);
    assign bus.Pausa           = (state_r == PAUSE);
    assign bus.Error_Overflow  = ovf_r;
    assign bus.Error_Underflow = unf_r;
    assign bus.Error_Fifo      = ovf_r | unf_r;
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_fifo_param;
    localparam int DW = 6;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    logic [DW-1:0] mq [$];
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_dout = '0;
    logic          m_pausa = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    typedef struct {
        logic          rst, psh, pp, clr;
        logic [DW-1:0] din;
        int            count;
        logic          valid;
        logic [DW-1:0] dout;
        logic          pausa, ovf, unf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_update(input logic r, pu, po, cl, input logic [DW-1:0] d);
        int  cnt;
        bit  pop_ok, push_ok;
        cnt     = mq.size();
        pop_ok  = po && (cnt > 0);
        push_ok = pu && ((cnt < DEPTH) || pop_ok);
        if (r) begin
            mq.delete();
            m_valid = 1'b0; m_dout = '0; m_pausa = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (pop_ok) begin
                m_dout  = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (push_ok) mq.push_back(d);
            if (mq.size() <= int'(bus.Umbral_Almost_Empty)) m_pausa = 1'b0;
            else if (mq.size() >= int'(bus.Umbral_Almost_Full)) m_pausa = 1'b1;
            m_ovf = (pu && !push_ok) ? 1'b1 : (cl ? 1'b0 : m_ovf);
            m_unf = (po && !pop_ok) ? 1'b1 : (cl ? 1'b0 : m_unf);
        end
    endtask

    task automatic compare_model(input string tag);
        int c;
        c = mq.size();
        chk({tag, " count"}, int'(bus.Fifo_Count), c);
        chk({tag, " valid"}, int'(bus.Fifo_Valid), int'(m_valid));
        chk({tag, " dout"}, int'(bus.Fifo_Data_out), int'(m_dout));
        chk({tag, " empty"}, int'(bus.Fifo_Empty), int'(c == 0));
        chk({tag, " full"}, int'(bus.Fifo_Full), int'(c == DEPTH));
        chk({tag, " almost_empty"}, int'(bus.Almost_Empty), int'(c <= int'(bus.Umbral_Almost_Empty)));
        chk({tag, " almost_full"}, int'(bus.Almost_Full), int'(c >= int'(bus.Umbral_Almost_Full)));
        chk({tag, " pausa"}, int'(bus.Pausa), int'(m_pausa));
        chk({tag, " ovf"}, int'(bus.Error_Overflow), int'(m_ovf));
        chk({tag, " unf"}, int'(bus.Error_Underflow), int'(m_unf));
        chk({tag, " err"}, int'(bus.Error_Fifo), int'(m_ovf | m_unf));
    endtask

    task automatic step(input string tag, input logic r, pu, po, cl, input logic [DW-1:0] d);
        reset = r; bus.push = pu; bus.pop = po; bus.Error_Clear = cl; bus.Fifo_Data_in = d;
        @(posedge clk);
        model_update(r, pu, po, cl, d);
        #1;
        compare_model(tag);
    endtask

    vec_t vt [$];

    initial begin
        reset = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.Error_Clear = 1'b0;
        bus.Fifo_Data_in = '0;
        bus.Umbral_Almost_Empty = 3'd1;
        bus.Umbral_Almost_Full  = 3'd3;

        //            rst   push  pop   clr   din    cnt valid dout   pausa ovf   unf
        vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h0A, 1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h0B, 2, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h0C, 3, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h0D, 4, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 3, 1'b1, 6'h0A, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 2, 1'b1, 6'h0B, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1, 1'b1, 6'h0C, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 0, 1'b1, 6'h0D, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 0, 1'b0, 6'h0D, 1'b0, 1'b0, 1'b0});
        // overflow on a full FIFO, then clear
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h01, 1, 1'b0, 6'h0D, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h02, 2, 1'b0, 6'h0D, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h03, 3, 1'b0, 6'h0D, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h04, 4, 1'b0, 6'h0D, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 6'h3F, 4, 1'b0, 6'h0D, 1'b1, 1'b1, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 3, 1'b1, 6'h01, 1'b1, 1'b1, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3, 1'b0, 6'h01, 1'b1, 1'b1, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 3, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 2, 1'b1, 6'h02, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1, 1'b1, 6'h03, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 0, 1'b1, 6'h04, 1'b0, 1'b0, 1'b0});
        // underflow on empty, then clear
        vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 0, 1'b0, 6'h04, 1'b0, 1'b0, 1'b1});
        vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 0, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < vt.size(); i++) begin
            step($sformatf("vec%0d", i), vt[i].rst, vt[i].psh, vt[i].pp, vt[i].clr, vt[i].din);
            chk($sformatf("vec%0d tbl_count", i), int'(bus.Fifo_Count), vt[i].count);
            chk($sformatf("vec%0d tbl_valid", i), int'(bus.Fifo_Valid), int'(vt[i].valid));
            chk($sformatf("vec%0d tbl_dout", i), int'(bus.Fifo_Data_out), int'(vt[i].dout));
            chk($sformatf("vec%0d tbl_pausa", i), int'(bus.Pausa), int'(vt[i].pausa));
            chk($sformatf("vec%0d tbl_ovf", i), int'(bus.Error_Overflow), int'(vt[i].ovf));
            chk($sformatf("vec%0d tbl_unf", i), int'(bus.Error_Underflow), int'(vt[i].unf));
            chk($sformatf("vec%0d tbl_full", i), int'(bus.Fifo_Full), int'(vt[i].count == DEPTH));
        end

        // Full FIFO with simultaneous push and pop: read returns the oldest word
        for (int i = 0; i < 4; i++) step("fill4", 1'b0, 1'b1, 1'b0, 1'b0, 6'(8'h11 + i));
        step("full_pushpop", 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);
        chk("full_pushpop count", int'(bus.Fifo_Count), 4);
        chk("full_pushpop dout", int'(bus.Fifo_Data_out), 8'h11);
        chk("full_pushpop valid", int'(bus.Fifo_Valid), 1);
        chk("full_pushpop err", int'(bus.Error_Fifo), 0);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 1'b0, 1'b1, 1'b0, 6'h00);
            chk($sformatf("drain%0d dout", i), int'(bus.Fifo_Data_out), (i < 3) ? (8'h12 + i) : 8'h15);
        end

        // Wrap-around at count 2
        step("pre_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 6'h20);
        step("pre_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 6'h21);
        for (int k = 0; k < 10; k++) begin
            step("wrap", 1'b0, 1'b1, 1'b1, 1'b0, 6'(k));
            chk($sformatf("wrap%0d dout", k), int'(bus.Fifo_Data_out), (k < 2) ? (8'h20 + k) : (k - 2));
            chk($sformatf("wrap%0d count", k), int'(bus.Fifo_Count), 2);
        end

        // Reset mid-traffic with a push in the same cycle
        step("to3", 1'b0, 1'b1, 1'b0, 1'b0, 6'h2A);
        chk("to3 count", int'(bus.Fifo_Count), 3);
        step("rst_push", 1'b1, 1'b1, 1'b1, 1'b0, 6'h33);
        chk("rst_push count", int'(bus.Fifo_Count), 0);
        chk("rst_push empty", int'(bus.Fifo_Empty), 1);
        chk("rst_push pausa", int'(bus.Pausa), 0);
        chk("rst_push valid", int'(bus.Fifo_Valid), 0);
        chk("rst_push err", int'(bus.Error_Fifo), 0);

        // Randomized traffic, thresholds occasionally reprogrammed (including overlap)
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                bus.Umbral_Almost_Empty = 3'($urandom_range(0, 7));
                bus.Umbral_Almost_Full  = 3'($urandom_range(0, 7));
            end
            step("rand", 1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 6'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the 6-bit, 4-entry flow-control FIFO.
- Generalised data width and depth, with runtime-programmable almost-empty/almost-full thresholds.
- Adds an explicit occupancy count, a registered read port with a valid strobe, Pausa with hysteresis, and sticky, separately flagged overflow/underflow errors.
- Sits between a producer and a consumer on a single clock domain; Pausa is the back-pressure signal to the producer.

Parameters:
- DATA_WIDTH, 6, width of each data word.
- ADDR_WIDTH, 2, pointer width; depth is DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request; Fifo_Data_in is sampled when the push is accepted.
- pop  input  1  read request.
- Fifo_Data_in  input  DATA_WIDTH  write data.
- Umbral_Almost_Empty  input  ADDR_WIDTH+1  almost-empty threshold, compared every cycle.
- Umbral_Almost_Full  input  ADDR_WIDTH+1  almost-full threshold, compared every cycle.
- Error_Clear  input  1  clears the sticky error bits.
- Fifo_Data_out  output  DATA_WIDTH  registered read data.
- Fifo_Valid  output  1  high for one cycle when Fifo_Data_out holds a newly popped word.
- Fifo_Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- Fifo_Empty  output  1  Fifo_Count == 0.
- Fifo_Full  output  1  Fifo_Count == DEPTH.
- Almost_Empty  output  1  Fifo_Count <= Umbral_Almost_Empty.
- Almost_Full  output  1  Fifo_Count >= Umbral_Almost_Full.
- Pausa  output  1  producer back-pressure, with hysteresis.
- Error_Overflow  output  1  sticky: a push was rejected.
- Error_Underflow  output  1  sticky: a pop was rejected.
- Error_Fifo  output  1  Error_Overflow OR Error_Underflow.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - Fifo_Data_out=0, Fifo_Valid=0, Pausa=0, both error bits=0.
  - As a result Fifo_Empty=1, Fifo_Full=0, Almost_Empty=1 and Almost_Full=(Umbral_Almost_Full==0).
  - Memory contents are not cleared.
  - Reset overrides every other input, including a push or pop in the same cycle.
  - Reset in the middle of traffic discards all stored data.
- Accept rules, evaluated on the pre-edge state:
  - pop_ok = pop & ~Fifo_Empty.
  - push_ok = push & (~Fifo_Full | pop_ok). A push into a full FIFO is accepted when a pop is accepted in the same cycle.
  - Push together with pop on an empty FIFO: the push is accepted and the pop is rejected. There is no fall-through.
- Pointers:
  - wr_ptr increments on push_ok; rd_ptr increments on pop_ok.
  - Both wrap naturally modulo DEPTH.
  - Memory write at wr_ptr on push_ok.
- Count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - Unchanged when both or neither are accepted.
  - Count never exceeds DEPTH and never goes below 0.
- Read latency is one cycle:
  - On pop_ok, mem[rd_ptr] is registered into Fifo_Data_out and Fifo_Valid=1 on the following cycle.
  - Otherwise Fifo_Valid=0 and Fifo_Data_out holds its last value.
  - When full and both requests are accepted, the read returns the old word at rd_ptr, never the incoming data.
- Flags:
  - Fifo_Empty, Fifo_Full, Almost_Empty and Almost_Full are combinational from the count register and the threshold inputs, so they reflect post-edge state with no additional lag.
- Pausa, a registered 2-state machine:
  - RUN (Pausa=0) -> PAUSE when next_count >= Umbral_Almost_Full.
  - PAUSE (Pausa=1) -> RUN when next_count <= Umbral_Almost_Empty.
  - If the thresholds overlap (AE >= AF), PAUSE->RUN takes priority.
- Errors:
  - Error_Overflow is set on push & ~push_ok; Error_Underflow is set on pop & ~pop_ok.
  - Both bits stay set until reset, or until a cycle with Error_Clear=1.
  - When Error_Clear coincides with a new error, the new error wins and the bit stays 1.
  - Rejected operations change no other state.
- Threshold inputs are not range-checked. Values above DEPTH simply leave the corresponding flag permanently 0 (Almost_Full) or 1 (Almost_Empty).

Test Plan (DATA_WIDTH=6, ADDR_WIDTH=2, Umbral_Almost_Empty=1, Umbral_Almost_Full=3):
1. Reset, then 4 pushes of 0x0A,0x0B,0x0C,0x0D -> count 1,2,3,4. Almost_Full at count 3; Pausa=1 from the edge making count 3; Fifo_Full=1 at count 4. Then 4 pops -> Fifo_Data_out 0x0A..0x0D, each with a 1-cycle Fifo_Valid pulse; Pausa drops when count reaches 1; Fifo_Empty=1 at the end.
2. Fill to 4 entries, then push 0x3F alone -> Error_Overflow=1, Error_Fifo=1, count stays 4. Pop -> returns the first word (0x3F is never read); the error stays set until Error_Clear=1 for one cycle, after which it reads 0.
3. Pop on an empty FIFO -> Error_Underflow=1, Fifo_Valid stays 0, count 0, pointers unchanged.
4. Full FIFO, push 0x15 together with pop -> count stays 4, no error, Fifo_Valid=1 with the oldest word. After 4 further pops, 0x15 emerges last.
5. Wrap-around: 10 cycles of simultaneous push/pop at count 2 with data 0..9 -> output order is preserved across pointer wrap, count stays 2.
6. Reset asserted with count=3 and push=1 in the same cycle -> count 0, Fifo_Empty=1, Pausa=0, errors 0, Fifo_Valid=0 on the next cycle.
